// File: rtl/prn_range_sampler_pkg.sv
// Shared definitions for the PRN range sampler: FSM encodings, default width, mask helper.
package prn_range_sampler_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // Smallest 2^k-1 covering the bound: smear the highest set bit into all lower bits.
    function automatic logic [31:0] mask_for(input logic [31:0] bound);
        logic [31:0] m;
        m = bound;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/prn_range_sampler_fifo.sv
// First-word-fall-through FIFO holding accepted samples; head entry is driven from storage.
module prn_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers (wrap modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prn_range_sampler.sv
// Mask-and-reject sampler turning a raw PRN byte stream into uniform integers in [0, range_max].
module prn_range_sampler
    import prn_range_sampler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] prn,
    input  logic             en,
    input  logic [WIDTH-1:0] range_max,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic [WIDTH-1:0] rej_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bound_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cand;
    logic             sampling;
    logic             accept;
    logic             reject;
    logic             push;
    logic             pop;
    logic             empty;

    assign sampling  = (state == ST_SAMPLE);
    assign cand      = prn & mask_q;
    assign accept    = sampling && (cand <= bound_q);
    assign reject    = sampling && (cand > bound_q);
    assign pop       = out_valid && out_ready;
    assign push      = accept && (!full || pop);
    assign out_valid = !empty;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a new bound is only taken after en has been low for a cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (en) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (!en) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Capture the bound and its covering mask during the single LOAD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bound_q <= '0;
            mask_q  <= '0;
        end else if (state == ST_LOAD) begin
            bound_q <= range_max;
            mask_q  <= WIDTH'(mask_for(32'(range_max)));
        end
    end

    // Saturating count of out-of-range candidates; FIFO-full drops are not rejections.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
        end else if (reject && (rej_cnt != '1)) begin
            rej_cnt <= rej_cnt + WIDTH'(1);
        end
    end

    prn_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cand),
        .dout  (out_data),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_prn_range_sampler.sv
// Directed-vector bench for prn_range_sampler with hand-computed expectations.
module tb_prn_range_sampler;

    logic       clk;
    logic       rst;
    logic [7:0] prn;
    logic       en;
    logic [7:0] range_max;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic [7:0] rej_cnt;

    int vectors;
    int errors;

    prn_range_sampler #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prn       (prn),
        .en        (en),
        .range_max (range_max),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .rej_cnt   (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; prn = 8'h00; range_max = 8'h00;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // en high: one edge into LOAD, one edge into SAMPLE; prn set afterwards is sampled next edge.
    task automatic start(input logic [7:0] rmax);
        range_max = rmax;
        en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== 1'b0 || full !== 1'b0 || rej_cnt !== 8'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_init: valid=%b full=%b rej=%0d data=%0d want 0 0 0 0", out_valid, full, rej_cnt, out_data);
        end
        start(8'd5);
        prn = 8'd1; tick();
        prn = 8'd2; tick();
        prn = 8'd7; tick();
        prn = 8'd3; en = 1'b0; tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd1 || rej_cnt !== 8'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_prefill: valid=%b data=%0d rej=%0d full=%b want 1 1 1 0", out_valid, out_data, rej_cnt, full);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || rej_cnt !== 8'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: valid=%b rej=%0d full=%b want 0 0 0", out_valid, rej_cnt, full);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reject_basic();
        do_reset();
        start(8'd5);
        prn = 8'h0E; tick();
        vectors++;
        if (rej_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reject_0e: rej=%0d valid=%b want 1 0", rej_cnt, out_valid);
        end
        prn = 8'h0B; tick();
        vectors++;
        if (out_data !== 8'd3 || out_valid !== 1'b1 || rej_cnt !== 8'd1) begin
            errors++;
            $display("FAIL accept_0b: data=%0d valid=%b rej=%0d want 3 1 1", out_data, out_valid, rej_cnt);
        end
    endtask

    task automatic test_range_zero();
        do_reset();
        start(8'd0);
        prn = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (full !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'd0 || rej_cnt !== 8'd0) begin
            errors++;
            $display("FAIL zero_fill: full=%b valid=%b data=%0d rej=%0d want 1 1 0 0", full, out_valid, out_data, rej_cnt);
        end
        out_ready = 1'b1; prn = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (full !== 1'b1 || out_data !== 8'd0 || rej_cnt !== 8'd0) begin
                errors++;
                $display("FAIL zero_drain%0d: full=%b data=%0d rej=%0d want 1 0 0", i, full, out_data, rej_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_head;
        do_reset();
        start(8'd255);
        for (int i = 1; i <= 4; i++) begin
            prn = 8'(i); tick();
        end
        vectors++;
        if (full !== 1'b1 || out_data !== 8'd1) begin
            errors++;
            $display("FAIL b2b_fill: full=%b data=%0d want 1 1", full, out_data);
        end
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            prn = 8'(i); tick();
            exp_head = 8'(i - 3);
            vectors++;
            if (full !== 1'b1 || out_data !== exp_head) begin
                errors++;
                $display("FAIL b2b_order%0d: full=%b data=%0d want 1 %0d", i, full, out_data, exp_head);
            end
        end
    endtask

    task automatic test_full_range();
        logic [7:0] pat [3];
        pat[0] = 8'h00; pat[1] = 8'h80; pat[2] = 8'hFF;
        do_reset();
        start(8'd255);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prn = pat[i]; tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== pat[i] || rej_cnt !== 8'd0) begin
                errors++;
                $display("FAIL full_range%0d: valid=%b data=%h rej=%0d want 1 %h 0", i, out_valid, out_data, rej_cnt, pat[i]);
            end
        end
    endtask

    task automatic test_mask_128();
        do_reset();
        start(8'd128);
        prn = 8'hC0; tick();
        vectors++;
        if (rej_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask128_rej: rej=%0d valid=%b want 1 0", rej_cnt, out_valid);
        end
        prn = 8'h7F; tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h7F) begin
            errors++;
            $display("FAIL mask128_acc: valid=%b data=%h want 1 7f", out_valid, out_data);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        start(8'd5);
        prn = 8'd1;
        for (int i = 0; i < 4; i++) tick();
        prn = 8'd2; tick(); tick();
        vectors++;
        if (full !== 1'b1 || rej_cnt !== 8'd0 || out_data !== 8'd1) begin
            errors++;
            $display("FAIL full_drop: full=%b rej=%0d data=%0d want 1 0 1", full, rej_cnt, out_data);
        end
        prn = 8'd7; tick();
        vectors++;
        if (rej_cnt !== 8'd1) begin
            errors++;
            $display("FAIL full_reject: rej=%0d want 1", rej_cnt);
        end
    endtask

    task automatic test_saturate_and_rebound();
        do_reset();
        start(8'd4);
        out_ready = 1'b1;
        prn = 8'h07;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (rej_cnt !== 8'd10) begin
            errors++;
            $display("FAIL rej_count10: rej=%0d want 10", rej_cnt);
        end
        for (int i = 0; i < 290; i++) tick();
        vectors++;
        if (rej_cnt !== 8'd255 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rej_saturate: rej=%0d valid=%b want 255 0", rej_cnt, out_valid);
        end
        range_max = 8'd255;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b0 || rej_cnt !== 8'd255) begin
            errors++;
            $display("FAIL bound_held: valid=%b rej=%0d want 0 255", out_valid, rej_cnt);
        end
        en = 1'b0; tick();
        en = 1'b1; tick(); tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h07) begin
            errors++;
            $display("FAIL bound_reload: valid=%b data=%h want 1 07", out_valid, out_data);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; prn = 8'h00; range_max = 8'h00;
        test_reset();
        test_reject_basic();
        test_range_zero();
        test_back_to_back();
        test_full_range();
        test_mask_128();
        test_full_drop();
        test_saturate_and_rebound();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
